producer_store_transaction_generator: RTL

Producer-side counterpart of the cohort consumer load path. Accepts 64-bit entries from the producer core, packs two consecutive entries into one 16-byte line, and issues line-store transactions into the in-memory FIFO at `addr_base` when the FIFO has room for two entries. It tracks issued and acknowledged tail pointers and exports the acknowledged tail to the coherency manager; the consumer side reads it as `fifo_ptr.tail`.

---
 rtl/producer_store_transaction_generator_pkg.sv | 72 +++++++
 rtl/producer_store_transaction_generator_if.sv | 12 +
 rtl/producer_store_transaction_generator_entry_pair_packer.sv | 62 ++++++
 rtl/producer_store_transaction_generator.sv | 125 ++++++++++++
 4 files changed

// File: rtl/producer_store_transaction_generator_pkg.sv
// Shared types and pointer helpers for the producer store path.
// Pointers are an index plus a wrap bit over a FIFO of fifo_length entries.
package producer_store_transaction_generator_pkg;

  localparam int ADDR_W     = 32;
  localparam int IDX_W      = 16;
  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = 8 * LINE_BYTES;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [IDX_W-1:0]  len_t;
  typedef logic [IDX_W:0]    cnt_t;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  typedef struct packed {
    ptr_t head;
    ptr_t tail;
  } fifo_ptr_t;

  typedef struct packed {
    addr_t     addr_base;
    len_t      fifo_length;
    fifo_ptr_t fifo_ptr;
  } fifo_config_t;

  typedef struct packed {
    addr_t             addr;
    logic [LINE_W-1:0] line;
  } store_trans_t;

  localparam int STORE_W = $bits(store_trans_t);

  typedef enum logic [1:0] {
    PK_EMPTY = 2'd0,
    PK_HALF  = 2'd1,
    PK_LINE  = 2'd2
  } pack_state_e;

  // Advance by one line (two entries), toggling wrap at the end.
  function automatic ptr_t inc_ptr_two(ptr_t p, len_t len);
    ptr_t r;
    cnt_t n;
    n = {1'b0, p.idx} + cnt_t'(2);
    if (n >= {1'b0, len}) begin
      r.idx  = IDX_W'(n - {1'b0, len});
      r.wrap = ~p.wrap;
    end else begin
      r.idx  = n[IDX_W-1:0];
      r.wrap = p.wrap;
    end
    return r;
  endfunction

  // Entries between from and to, walking forward.
  function automatic cnt_t ptr_used(ptr_t from, ptr_t to, len_t len);
    if (from.wrap == to.wrap)
      return {1'b0, to.idx} - {1'b0, from.idx};
    else
      return {1'b0, len} - {1'b0, from.idx} + {1'b0, to.idx};
  endfunction

  function automatic logic fifo_has_two_free(ptr_t head, ptr_t tail, len_t len);
    cnt_t used;
    used = ptr_used(head, tail, len);
    return ({1'b0, len} - used) >= cnt_t'(2);
  endfunction

endpackage

// File: rtl/producer_store_transaction_generator_if.sv
// Valid/ready handshake bundle with a flat data payload.
// Master drives valid and data; slave drives ready.
interface producer_store_transaction_generator_if #(
  parameter int W = 64
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/producer_store_transaction_generator_entry_pair_packer.sv
// Packs two consecutive entries into one line; holds it until issued.
// No bypass: a full line blocks further entries until it leaves.
module producer_store_transaction_generator_entry_pair_packer
  import producer_store_transaction_generator_pkg::*;
#(
  parameter int ENTRY_W = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid_i,
  input  logic [ENTRY_W-1:0]   push_data_i,
  output logic                 push_ready_o,
  input  logic                 issue_i,
  output logic                 line_valid_o,
  output logic [2*ENTRY_W-1:0] line_o
);

  pack_state_e          state_q, state_d;
  logic [2*ENTRY_W-1:0] line_q, line_d;
  logic                 push_hs;

  assign push_ready_o = ~rst & (state_q != PK_LINE);
  assign push_hs      = push_valid_i & push_ready_o;
  assign line_valid_o = (state_q == PK_LINE);
  assign line_o       = line_q;

  // State and line register; reset drops any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PK_EMPTY;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
    end
  end

  // Low half first, then high half, then wait for the issue handshake.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    unique case (state_q)
      PK_EMPTY: begin
        if (push_hs) begin
          state_d               = PK_HALF;
          line_d[ENTRY_W-1:0]   = push_data_i;
        end
      end
      PK_HALF: begin
        if (push_hs) begin
          state_d                       = PK_LINE;
          line_d[2*ENTRY_W-1:ENTRY_W]   = push_data_i;
        end
      end
      PK_LINE: begin
        if (issue_i) state_d = PK_EMPTY;
      end
      default: state_d = PK_EMPTY;
    endcase
  end

endmodule

// File: rtl/producer_store_transaction_generator.sv
// Issues packed line stores into the in-memory FIFO and tracks
// issued/acked tails; the acked tail is what the consumer sees.
module producer_store_transaction_generator
  import producer_store_transaction_generator_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int ENTRY_W         = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  fifo_config_t                                  fifo_config_r,
  producer_store_transaction_generator_if.slave         push_data,
  producer_store_transaction_generator_if.master        trans_info,
  input  logic                                          trans_ack,
  output ptr_t                                          producer_tail_ptr_o
);

  if (ENTRY_W != 64) begin : g_entry_w_chk
    $error("ENTRY_W must be 64");
  end
  if (MAX_OUTSTANDING < 1) begin : g_max_out_chk
    $error("MAX_OUTSTANDING must be at least 1");
  end

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  typedef logic [OUT_W-1:0] out_t;
  localparam out_t MAX_OUT = out_t'(MAX_OUTSTANDING);

  ptr_t              tail_issued_q, tail_issued_d;
  ptr_t              tail_acked_q, tail_acked_d;
  out_t              outstanding_q, outstanding_d;
  logic              line_valid;
  logic [LINE_W-1:0] line;
  logic              has_two_free;
  logic              credit_ok;
  logic              trans_valid;
  logic              issue;
  logic              ack_ok;
  addr_t             line_off;
  store_trans_t      trans;
  logic              unused_cfg;

  assign unused_cfg = ^fifo_config_r.fifo_ptr.tail;

  producer_store_transaction_generator_entry_pair_packer #(
    .ENTRY_W (ENTRY_W)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (push_data.valid),
    .push_data_i  (push_data.data),
    .push_ready_o (push_data.ready),
    .issue_i      (issue),
    .line_valid_o (line_valid),
    .line_o       (line)
  );

  assign has_two_free = fifo_has_two_free(
    fifo_config_r.fifo_ptr.head,
    tail_issued_q,
    fifo_config_r.fifo_length
  );

  assign credit_ok   = (outstanding_q < MAX_OUT);
  assign trans_valid = ~rst & line_valid & has_two_free & credit_ok;
  assign issue       = trans_valid & trans_info.ready;
  assign ack_ok      = trans_ack & (outstanding_q != '0);

  assign line_off   = addr_t'(tail_issued_q.idx >> 1) << $clog2(LINE_BYTES);
  assign trans.addr = fifo_config_r.addr_base + line_off;
  assign trans.line = line;

  assign trans_info.valid = trans_valid;
  assign trans_info.data  = trans;

  assign producer_tail_ptr_o = tail_acked_q;

  // Tail pointers advance one line per issue / per accepted ack.
  always_comb begin
    tail_issued_d = tail_issued_q;
    tail_acked_d  = tail_acked_q;
    if (issue)
      tail_issued_d = inc_ptr_two(tail_issued_q, fifo_config_r.fifo_length);
    if (ack_ok)
      tail_acked_d = inc_ptr_two(tail_acked_q, fifo_config_r.fifo_length);
  end

  // Credit count; simultaneous issue and ack cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    unique case (1'b1)
      issue & ~ack_ok: outstanding_d = outstanding_q + out_t'(1);
      ack_ok & ~issue: outstanding_d = outstanding_q - out_t'(1);
      default: ;
    endcase
  end

  // Pointer and credit state; reset forgets any in-flight stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_issued_q <= '0;
      tail_acked_q  <= '0;
      outstanding_q <= '0;
    end else begin
      tail_issued_q <= tail_issued_d;
      tail_acked_q  <= tail_acked_d;
      outstanding_q <= outstanding_d;
    end
  end

  cnt_t acked_gap;
  assign acked_gap = ptr_used(tail_acked_q, tail_issued_q,
                              fifo_config_r.fifo_length);

  a_ack_has_store: assert property (
    @(posedge clk) disable iff (rst)
    trans_ack |-> (outstanding_q != '0)
  ) else $warning("trans_ack with no store outstanding ignored");

  a_acked_behind_issued: assert property (
    @(posedge clk) disable iff (rst)
    acked_gap == (cnt_t'(outstanding_q) << 1)
  ) else $error("acked tail out of step with issued tail");

endmodule
